fp_norm_pack: RTL and testbench

- Back end of the single-precision add datapath: takes the un-normalized mantissa sum and the big-operand exponent/sign.
- Normalizes, rounds round-to-nearest-even and packs an IEEE-754 binary32 word.
- Three-stage pipeline with valid/ready handshake on both sides; sits between the mantissa adder and the MAC accumulator register.

---
 rtl/fp_norm_pack.sv | 208 ++++++++++++++++++++
 tb/tb_fp_norm_pack.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack.sv
// fp_norm_pack
// Back end of the single-precision add datapath. The block takes the
// un-normalized mantissa sum with the exponent and sign of the larger operand.
// It normalizes the sum, rounds it to nearest-even and packs an IEEE-754
// binary32 word. Denormal results are flushed to signed zero.
//
// The design is a three-stage pipeline: normalize, round, pack. A single
// global enable advances all stages together, so backpressure from the
// output stalls the whole pipe and bubbles are kept.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (control and output registers)
//   in_valid     input beat valid
//   in_ready     block accepts a beat this cycle (equal to the pipe enable)
//   in_sign      result sign
//   in_exp       biased exponent of the larger operand
//   in_man       [26] carry-out, [25] hidden bit, [24:2] fraction,
//                [1] guard, [0] sticky
//   out_valid    packed result valid
//   out_ready    downstream accepts the result
//   out_data     {sign, exp[7:0], frac[22:0]}
//   out_ovf      this result overflowed
//   out_unf      this result was flushed to zero by underflow
//   out_inexact  guard or sticky was nonzero after normalization
//
// Build option
//   FP_NORM_SAT_EN  when defined, overflow returns the largest finite
//                   magnitude instead of infinity (out_ovf is still set).

module fp_norm_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [FRAC_W+3:0]     in_man,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_data,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic                  out_inexact
);

    // hidden + fraction + guard + sticky
    localparam int NORM_W = FRAC_W + 3;
    // signed internal exponent with room for both overflow and underflow
    localparam int XW     = EXP_W + 2;
    localparam int LZC_W  = $clog2(NORM_W + 1);

    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXP_W) - 1);

    // Leading zeros of the mantissa below the carry bit. An all-zero input
    // returns NORM_W, and a shift by that amount also produces zero.
    function automatic logic [LZC_W-1:0] leadZeros(input logic [NORM_W-1:0] v);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = LZC_W'(NORM_W);
        found = 1'b0;
        for (int i = NORM_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZC_W'(NORM_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on {frac, guard, sticky}. The function returns
    // {carry, frac}. The hidden bit of a normalized nonzero value is always
    // 1, so a carry out of the fraction is exactly a mantissa overflow. When
    // that happens the fraction is already all zeros.
    function automatic logic [FRAC_W:0] rneRound(input logic [NORM_W-2:0] m);
        logic roundUp;
        roundUp = m[1] & (m[0] | m[2]);
        return {1'b0, m[NORM_W-2:2]} + {{FRAC_W{1'b0}}, roundUp};
    endfunction

    // Range checks and final packing. The function returns {ovf, unf, word}.
    function automatic logic [EXP_W+FRAC_W+2:0] packResult(
        input logic                 sign,
        input logic signed [XW-1:0] exp,
        input logic [FRAC_W-1:0]    frac,
        input logic                 zero
    );
        logic [EXP_W+FRAC_W:0] word;
        logic                  ovf;
        logic                  unf;
        word = {sign, {(EXP_W + FRAC_W){1'b0}}};
        ovf  = 1'b0;
        unf  = 1'b0;
        if (zero) begin
            ovf = 1'b0;
        end else if (exp <= EXP_ZERO) begin
            unf = 1'b1;
        end else if (exp >= EXP_INF) begin
            ovf = 1'b1;
`ifdef FP_NORM_SAT_EN
            word = {sign, EXP_W'((1 << EXP_W) - 2), {FRAC_W{1'b1}}};
`else
            word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`endif
        end else begin
            word = {sign, exp[EXP_W-1:0], frac};
        end
        return {ovf, unf, word};
    endfunction

    logic en;

    logic [LZC_W-1:0]        lz;
    logic signed [XW-1:0]    expIn;
    logic signed [XW-1:0]    expNorm;
    logic [NORM_W-1:0]       manNorm;

    logic                    vld_p1;
    logic                    sign_p1;
    logic signed [XW-1:0]    exp_p1;
    logic [NORM_W-1:0]       man_p1;

    logic [FRAC_W:0]         rounded;
    logic signed [XW-1:0]    expRnd;
    logic [FRAC_W-1:0]       fracRnd;
    logic                    inxRnd;

    logic                    vld_p2;
    logic                    sign_p2;
    logic signed [XW-1:0]    exp_p2;
    logic [FRAC_W-1:0]       frac_p2;
    logic                    zero_p2;
    logic                    inx_p2;

    logic [EXP_W+FRAC_W+2:0] packed_w;
    logic                    inxOut;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // ---- stage 1: normalize ----
    always_comb begin
        lz      = leadZeros(in_man[NORM_W-1:0]);
        expIn   = $signed({{(XW - EXP_W){1'b0}}, in_exp});
        manNorm = in_man[NORM_W-1:0] << lz;
        expNorm = expIn - $signed({{(XW - LZC_W){1'b0}}, lz});
        if (in_man[NORM_W]) begin
            // Carry-out: shift right one place. The dropped bit goes into sticky.
            manNorm = {in_man[NORM_W:2], in_man[1] | in_man[0]};
            expNorm = expIn + EXP_ONE;
        end
    end

    // ---- stage 2: round ----
    always_comb begin
        rounded = rneRound(man_p1[NORM_W-2:0]);
        fracRnd = rounded[FRAC_W-1:0];
        expRnd  = rounded[FRAC_W] ? exp_p1 + EXP_ONE : exp_p1;
        inxRnd  = man_p1[1] | man_p1[0];
    end

    // ---- stage 3: pack ----
    always_comb begin
        packed_w = packResult(sign_p2, exp_p2, frac_p2, zero_p2);
        inxOut   = zero_p2 ? 1'b0 : inx_p2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (en) begin
            vld_p1      <= in_valid;
            vld_p2      <= vld_p1;
            out_valid   <= vld_p2;
            out_ovf     <= packed_w[EXP_W+FRAC_W+2];
            out_unf     <= packed_w[EXP_W+FRAC_W+1];
            out_data    <= packed_w[EXP_W+FRAC_W:0];
            out_inexact <= inxOut;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1 <= in_sign;
            exp_p1  <= expNorm;
            man_p1  <= manNorm;
            sign_p2 <= sign_p1;
            exp_p2  <= expRnd;
            frac_p2 <= fracRnd;
            // A normalized nonzero mantissa always carries the hidden bit,
            // so a clear hidden bit means the sum was zero.
            zero_p2 <= ~man_p1[NORM_W-1];
            inx_p2  <= inxRnd;
        end
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Testbench for fp_norm_pack.
// The bench uses directed spec vectors, a backpressure burst, reset during
// traffic and randomized traffic. All of them are checked against a
// real-number-style reference model of normalize, round-to-nearest-even and
// pack.

module tb_fp_norm_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int          nChecks = 0;
    int          nErrors = 0;
    int          delivered = 0;
    logic [34:0] expQ[$];
    bit          holding = 1'b0;
    logic [34:0] heldVal;

    fp_norm_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model. It finds the MSB of the sum and keeps 24 significant
    // bits. The first dropped bit is the guard bit. Any lower dropped bit
    // counts as sticky. The model then applies RNE and classifies the
    // exponent. The result is returned as {ovf, unf, inexact, word}.
    function automatic logic [34:0] refModel(input logic s, input logic [7:0] e8, input logic [26:0] m);
        int              p;
        int              e;
        int              drop;
        longint unsigned mm;
        longint unsigned sig;
        bit              g;
        bit              st;
        bit              inx;
        bit              ovf;
        bit              unf;
        logic [31:0]     d;
        if (m == 27'd0) return {3'b000, s, 31'd0};
        mm = {37'd0, m};
        p  = 26;
        while (m[p] == 1'b0) p--;
        e = int'(e8) + p - 25;
        if (p > 23) begin
            drop = p - 23;
            sig  = mm >> drop;
            g    = mm[drop-1];
            st   = (mm & ((64'd1 << (drop - 1)) - 64'd1)) != 64'd0;
        end else begin
            sig = mm << (23 - p);
            g   = 1'b0;
            st  = 1'b0;
        end
        inx = g | st;
        if (g && (st || sig[0])) sig = sig + 64'd1;
        if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            e   = e + 1;
        end
        ovf = 1'b0;
        unf = 1'b0;
        if (e <= 0) begin
            d   = {s, 31'd0};
            unf = 1'b1;
        end else if (e >= 255) begin
            ovf = 1'b1;
`ifdef FP_NORM_SAT_EN
            d = {s, 8'hFE, 23'h7FFFFF};
`else
            d = {s, 8'hFF, 23'd0};
`endif
        end else begin
            d = {s, 8'(e), sig[22:0]};
        end
        return {ovf, unf, inx, d};
    endfunction

    // Scoreboard. It records accepted beats and compares delivered results
    // in order. It also checks that a stalled output holds and that in_ready
    // follows the enable rule.
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            checkEq("inReady", in_ready, !out_valid || out_ready);
            if (holding) checkEq("hold", {out_ovf, out_unf, out_inexact, out_data}, heldVal);
            holding = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        checkEq("spurious", out_valid, 1'b0);
                    end else begin
                        checkEq("result", {out_ovf, out_unf, out_inexact, out_data}, expQ.pop_front());
                        delivered++;
                    end
                end else begin
                    holding = 1'b1;
                    heldVal = {out_ovf, out_unf, out_inexact, out_data};
                end
            end
            if (in_valid && in_ready) expQ.push_back(refModel(in_sign, in_exp, in_man));
        end
    end

    task automatic randBeat();
        int mode;
        in_sign = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       in_exp = 8'($urandom_range(0, 4));
            1:       in_exp = 8'($urandom_range(250, 255));
            default: in_exp = 8'($urandom_range(0, 255));
        endcase
        mode = $urandom_range(0, 5);
        case (mode)
            0:       in_man = 27'h4000000 | 27'($urandom);
            1:       in_man = 27'h2000000 | 27'($urandom_range(0, 27'h1FFFFFF));
            2:       in_man = 27'($urandom) >> $urandom_range(0, 26);
            3:       in_man = 27'd0;
            4:       in_man = (27'h2000000 | 27'($urandom_range(0, 27'h1FFFFFF))) & 27'h7FFFFFE | 27'd2;
            default: in_man = 27'($urandom);
        endcase
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                            input logic [31:0] wantData, input logic [2:0] wantFlags);
        int lat;
        out_ready = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_man    = m;
        in_valid  = 1'b1;
        @(negedge clk);
        checkEq({tag, "Rdy"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        checkEq({tag, "Lat"}, lat, 3);
        checkEq({tag, "Data"}, out_data, wantData);
        checkEq({tag, "Flags"}, {out_ovf, out_unf, out_inexact}, wantFlags);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_man    = 27'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("rstVld", out_valid, 1'b0);
        checkEq("rstData", out_data, 32'd0);
        checkEq("rstFlags", {out_ovf, out_unf, out_inexact}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkEq("rstReady", in_ready, 1'b1);

        directed("onePlusOne", 1'b0, 8'd127, 27'h4000000, 32'h40000000, 3'b000);
        directed("negTwo",     1'b1, 8'd127, 27'h4000000, 32'hC0000000, 3'b000);
        directed("cancel",     1'b0, 8'd127, 27'h0040000, 32'h3C000000, 3'b000);
        directed("tieOdd",     1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 3'b001);
        directed("tieEven",    1'b0, 8'd127, 27'h2000002, 32'h3F800000, 3'b001);
        directed("aboveHalf",  1'b0, 8'd127, 27'h2000003, 32'h3F800001, 3'b001);
        directed("carrySticky",1'b0, 8'd127, 27'h4000001, 32'h40000000, 3'b001);
`ifdef FP_NORM_SAT_EN
        directed("ovf",        1'b0, 8'd254, 27'h4000000, 32'h7F7FFFFF, 3'b100);
        directed("ovfExp255",  1'b1, 8'd255, 27'h2000000, 32'hFF7FFFFF, 3'b100);
`else
        directed("ovf",        1'b0, 8'd254, 27'h4000000, 32'h7F800000, 3'b100);
        directed("ovfExp255",  1'b1, 8'd255, 27'h2000000, 32'hFF800000, 3'b100);
`endif
        directed("unf",        1'b0, 8'd3,   27'h0100000, 32'h00000000, 3'b010);
        directed("exp0Flush",  1'b1, 8'd0,   27'h2000000, 32'h80000000, 3'b010);
        directed("exp0Carry",  1'b0, 8'd0,   27'h4000000, 32'h00800000, 3'b000);
        directed("zero",       1'b1, 8'd100, 27'h0000000, 32'h80000000, 3'b000);

        // Backpressure: five back-to-back beats with the output stalled in
        // cycles 4 through 8.
        base = delivered;
        sent = 0;
        randBeat();
        for (int cyc = 1; cyc <= 40 && (delivered - base) < 5; cyc++) begin
            bit acc;
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (sent < 5);
            @(negedge clk);
            if (cyc >= 4 && cyc <= 8) checkEq("bpReady", in_ready, 1'b0);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                randBeat();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkEq("bpCount", delivered - base, 5);
        checkEq("bpQueue", expQ.size(), 0);

        // Randomized traffic with random stalls
        for (int i = 0; i < 600; i++) begin
            randBeat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 50 && expQ.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        checkEq("drain", expQ.size(), 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            randBeat();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int w = 0; w < 10 && !out_valid; w++) begin
            @(posedge clk);
            #1;
        end
        checkEq("rstPreVld", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkEq("rstAsyncVld", out_valid, 1'b0);
        checkEq("rstAsyncData", out_data, 32'd0);
        expQ.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkEq("noStale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        directed("postRst", 1'b0, 8'd127, 27'h0040000, 32'h3C000000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
